// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//   Sequential WIDTH-bit adder. One 4-bit slice is added per cycle through a
//   single Conditional_sum_adder_4bit; the slice carry is registered and fed
//   back as the carry-in of the next slice.
//   {C_out, S} = A + B + C_in; V flags signed (two's complement) overflow.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   A, B, C_in valid
//   in_ready   out  operands can be accepted (high only in IDLE)
//   A, B       in   WIDTH-bit operands
//   C_in       in   carry into slice 0
//   out_valid  out  S, C_out, V valid (high only in DONE)
//   out_ready  in   downstream accepts the result
//   S          out  registered WIDTH-bit sum
//   C_out      out  registered carry out of the MSB slice
//   V          out  registered signed overflow flag
// -----------------------------------------------------------------------------

// 4-bit conditional-sum adder: every bit is summed for both possible carry-ins,
// pairs are merged by selecting on the lower carry, then the two pairs are
// merged the same way. The real carry-in only drives the final multiplexers.
module Conditional_sum_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] s0, s1, c0, c1;   // per-bit sum/carry assuming carry-in 0 / 1
  logic [1:0] lo_s0, lo_s1, hi_s0, hi_s1;
  logic       lo_c0, lo_c1, hi_c0, hi_c1;
  logic [1:0] lo_s, hi_s;
  logic       lo_c;

  assign s0 = a ^ b;
  assign s1 = ~(a ^ b);
  assign c0 = a & b;
  assign c1 = a | b;

  // Level 1: bits [1:0] and [3:2], each resolved for both group carry-ins.
  assign lo_s0 = {c0[0] ? s1[1] : s0[1], s0[0]};
  assign lo_c0 =  c0[0] ? c1[1] : c0[1];
  assign lo_s1 = {c1[0] ? s1[1] : s0[1], s1[0]};
  assign lo_c1 =  c1[0] ? c1[1] : c0[1];

  assign hi_s0 = {c0[2] ? s1[3] : s0[3], s0[2]};
  assign hi_c0 =  c0[2] ? c1[3] : c0[3];
  assign hi_s1 = {c1[2] ? s1[3] : s0[3], s1[2]};
  assign hi_c1 =  c1[2] ? c1[3] : c0[3];

  // Level 2: the real carry-in picks the low pair, whose carry picks the high pair.
  assign lo_s = cin  ? lo_s1 : lo_s0;
  assign lo_c = cin  ? lo_c1 : lo_c0;
  assign hi_s = lo_c ? hi_s1 : hi_s0;
  assign cout = lo_c ? hi_c1 : hi_c0;
  assign sum  = {hi_s, lo_s};
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             V
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b;   // shift right one nibble per slice
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             last_slice;

  Conditional_sum_adder_4bit u_csa (
    .a    (op_a[3:0]),
    .b    (op_b[3:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  assign last_slice = (idx == LAST_IDX);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      S     <= '0;
      C_out <= 1'b0;
      V     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= A;
            op_b  <= B;
            carry <= C_in;
            idx   <= '0;
          end
        end
        RUN: begin
          S[4*idx +: 4] <= nib_sum;
          carry         <= nib_cout;
          op_a          <= op_a >> 4;
          op_b          <= op_b >> 4;
          idx           <= idx + IDX_W'(1);
          if (last_slice) begin
            // On the last slice the low nibble of each shift register holds
            // the operand's top nibble, so bit 3 is the operand sign bit.
            C_out <= nib_cout;
            V     <= (op_a[3] == op_b[3]) && (nib_sum[3] != op_a[3]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//   Directed and random stimulus for nibble_serial_adder (WIDTH=16). Expected
//   results come from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A, B;
  logic             C_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             V;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accept_cyc;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .C_in      (C_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .C_out     (C_out),
    .V         (V)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum with carry, overflow when the signed sum leaves range.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       output logic [15:0] s, output logic co, output logic v);
    int unsigned us;
    int ss;
    us = int'(a) + int'(b) + int'(ci);
    s  = us[15:0];
    co = us[16];
    ss = int'($signed(a)) + int'($signed(b)) + int'(ci);
    v  = (ss > 32767) || (ss < -32768);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge, then scramble the inputs.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    A = a; B = b; C_in = ci;
    tick();
    accept_cyc = cyc;
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom); C_in = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency_edges", 32'(n), 32'd4);
    check("in_ready_in_done", 32'(in_ready), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [15:0] a,
                              input logic [15:0] b, input logic ci);
    logic [15:0] es;
    logic        eco, ev;
    model(a, b, ci, es, eco, ev);
    check({tag, "_S"}, 32'(S), 32'(es));
    check({tag, "_C_out"}, 32'(C_out), 32'(eco));
    check({tag, "_V"}, 32'(V), 32'(ev));
  endtask

  // Result handshake with out_ready already high: one edge back to IDLE.
  task automatic release_result();
    out_ready = 1'b1;
    tick();
    check("out_valid_one_cycle", 32'(out_valid), 32'd0);
    check("in_ready_after_done", 32'(in_ready), 32'd1);
  endtask

  task automatic full_op(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input logic ci);
    send(a, b, ci);
    wait_done();
    check_result(tag, a, b, ci);
    release_result();
  endtask

  initial begin
    logic [15:0] hold_s;
    logic        hold_c, hold_v;
    int          first_acc;
    bit          saw_valid;

    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; C_in = 1'b0; out_ready = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_S", 32'(S), 32'd0);
    check("reset_C_out", 32'(C_out), 32'd0);
    check("reset_V", 32'(V), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    full_op("basic", 16'h1234, 16'h4321, 1'b0);
    check("basic_S_const", 32'(S), 32'h5555);
    full_op("ripple", 16'hFFFF, 16'h0001, 1'b0);
    check("ripple_C_out_const", 32'(C_out), 32'd1);
    full_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0);
    check("pos_ovf_V_const", 32'(V), 32'd1);
    full_op("neg_ovf", 16'h8000, 16'h8000, 1'b0);

    // Back-to-back with carry-in: initiation interval of 6 cycles.
    send(16'hFFFF, 16'h0000, 1'b1);
    first_acc = accept_cyc;
    wait_done();
    check_result("cin_ripple", 16'hFFFF, 16'h0000, 1'b1);
    release_result();
    send(16'h0F0F, 16'hF0F1, 1'b0);
    check("initiation_interval", 32'(accept_cyc - first_acc), 32'd6);
    wait_done();
    check_result("b2b_second", 16'h0F0F, 16'hF0F1, 1'b0);
    release_result();

    // Backpressure in DONE with new operands offered.
    out_ready = 1'b0;
    send(16'h8001, 16'hC003, 1'b1);
    wait_done();
    hold_s = S; hold_c = C_out; hold_v = V;
    check_result("bp", 16'h8001, 16'hC003, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      A = 16'($urandom); B = 16'($urandom); C_in = 1'($urandom);
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_S_stable", 32'(S), 32'(hold_s));
      check("bp_C_stable", 32'({C_out, V}), 32'({hold_c, hold_v}));
    end
    in_valid = 1'b0;
    release_result();

    // Reset in the middle of an operation.
    send(16'h1234, 16'h4321, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_S", 32'(S), 32'd0);
    check("midrst_flags", 32'({C_out, V, out_valid}), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_result", 32'(saw_valid), 32'd0);
    full_op("after_rst", 16'h0001, 16'h0001, 1'b0);
    check("after_rst_S_const", 32'(S), 32'h0002);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      full_op("rand", ra, rb, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Sequential wide-operand adder. Processes WIDTH-bit operands one 4-bit slice per cycle through a single instance of the team's existing 4-bit conditional-sum adder (Conditional_sum_adder_4bit).
- Registers the slice carry-out and feeds it back as the next slice's carry-in.
- Sits directly around the 4-bit adder: feeds it operand nibbles and carry, consumes its sum/carry outputs.
- Exposes valid/ready handshakes on the operand side and the result side.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8 (elaboration error otherwise).
NSLICE, WIDTH/4, derived localparam: number of 4-bit slices/cycles per operation.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands A, B, C_in are valid.
in_ready  output  1  block can accept operands; high only in IDLE.
A  input  WIDTH  operand A, unsigned or two's complement.
B  input  WIDTH  operand B.
C_in  input  1  carry-in to slice 0.
out_valid  output  1  result S/C_out/V is valid; high only in DONE.
out_ready  input  1  downstream accepts result.
S  output  WIDTH  registered sum.
C_out  output  1  registered carry out of the MSB slice.
V  output  1  registered signed overflow flag.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, S=0, C_out=0, V=0, out_valid=0, slice index=0, carry register=0, operand registers=0.
- in_ready is decoded from the state, so it reads 1 during and after reset.
- Reset mid-operation aborts the operation with no result produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On rising edge with in_valid=1: capture A, B into operand shift registers and C_in into the carry register; clear index; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, drive nibble[index] of the captured A and B plus the carry register into the 4-bit adder.
  - At the edge: write the adder sum into S[4*index+3:4*index], load the adder carry into the carry register, increment index.
  - At the edge where index==NSLICE-1:
    - C_out <= adder carry.
    - V <= (A_msb==B_msb) && (new S msb != A_msb), using the captured operands.
    - Go to DONE.
- DONE:
  - out_valid=1; S, C_out and V are held stable.
  - On an edge with out_ready=1: go to IDLE.
  - S, C_out and V keep their values until the next operation overwrites them.
- Latency: out_valid rises exactly NSLICE edges after the input acceptance edge (4 for WIDTH=16).
- Minimum initiation interval: NSLICE+2 cycles. No input is accepted in the same cycle as the result handshake.
- S nibbles not yet written during RUN show stale values. They are architecturally don't-care until out_valid=1.
- in_valid while in RUN or DONE is ignored; the operands are not captured.
- A and B may change after the acceptance edge without affecting the result.
- out_ready may be high before DONE; it has no effect outside DONE.
- Arithmetic: {C_out,S} = A + B + C_in, modulo 2^(WIDTH+1). The carry chain passes through every slice with no lookahead across slices.

Test Plan:
- WIDTH=16, A=0x1234, B=0x4321, C_in=0, out_ready=1 -> S=0x5555, C_out=0, V=0; out_valid high 4 edges after acceptance, for 1 cycle; in_ready back to 1 the next cycle.
- A=0xFFFF, B=0x0001, C_in=0 -> S=0x0000, C_out=1, V=0 (carry ripples through all 4 slices).
- A=0x7FFF, B=0x0001 -> S=0x8000, C_out=0, V=1. A=0x8000, B=0x8000 -> S=0x0000, C_out=1, V=1.
- A=0xFFFF, B=0x0000, C_in=1 -> S=0x0000, C_out=1. Back-to-back operations then give results in order, with a 6-cycle initiation interval.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands -> S/C_out/V stable, in_ready=0, new operands not captured. Then raise out_ready -> IDLE.
- Assert rst_n=0 for 1 cycle during RUN (after 2 slices) -> all outputs 0 immediately, out_valid never rises for that operation, in_ready=1. A fresh 0x0001+0x0001 then gives 0x0002.
